// File: rtl/prog_cache.sv
// Direct-mapped read-only instruction cache on the CPU program-fetch port.
// Hits return the word one cycle after the address; misses stall the PC while a line is refilled.
module prog_cache #(
  parameter int LINE_WORDS = 8,
  parameter int LINES      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] prg_address,
  output logic [15:0] instruction,
  output logic        p_cache_miss,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int AW = OB + IB;
  localparam int LW = 32 - OB;
  localparam int TW = LW - IB;
  localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_RESTART} state_t;

  logic [15:0]      r_data_ram [LINES*LINE_WORDS];
  logic [TW-1:0]    r_tag_ram  [LINES];
  logic [LINES-1:0] r_valid;

  logic [LW-1:0]    r_line_p1;
  logic [15:0]      r_data_p1;
  logic [TW-1:0]    r_tag_p1;
  logic             r_vld_p1;

  logic [LW-1:0]    r_miss_line;
  logic [OB-1:0]    r_cnt;
  logic             r_flush_pend;
  state_t           r_state;

  logic             w_hit;
  logic             w_miss_idle;
  logic             w_fill_wr;
  logic             w_fill_last;

  function automatic logic [IB-1:0] f_index(input logic [LW-1:0] line);
    return line[IB-1:0];
  endfunction

  function automatic logic [TW-1:0] f_tag(input logic [LW-1:0] line);
    return line[LW-1:IB];
  endfunction

  assign w_hit       = r_vld_p1 & r_valid[f_index(r_line_p1)] & (r_tag_p1 == f_tag(r_line_p1));
  assign w_miss_idle = r_vld_p1 & ~w_hit;
  assign w_fill_wr   = (r_state == S_FILL) & mem_rvalid;
  assign w_fill_last = w_fill_wr & (r_cnt == LAST_WORD);

  assign p_cache_miss = (r_state != S_IDLE) | w_miss_idle;
  assign instruction  = r_data_p1;

  // ---- p0 -> p1: register fetch address, synchronous RAM reads, fill writes
  always_ff @(posedge clk) begin
    r_line_p1 <= prg_address[31:OB];
    r_data_p1 <= r_data_ram[prg_address[AW-1:0]];
    r_tag_p1  <= r_tag_ram[prg_address[AW-1:OB]];
    if (r_state == S_IDLE && w_miss_idle)
      r_miss_line <= r_line_p1;
    if (w_fill_wr)
      r_data_ram[{f_index(r_miss_line), r_cnt}] <= mem_rdata;
    if (w_fill_last)
      r_tag_ram[f_index(r_miss_line)] <= f_tag(r_miss_line);
  end

  // ---- p1: control FSM; valid bits live here so rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vld_p1     <= 1'b0;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_cnt        <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      r_vld_p1 <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (flush)
            r_valid <= '0;
          if (w_miss_idle) begin
            r_state  <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= {r_line_p1, {OB{1'b0}}};
          end
        end
        S_REQ: begin
          if (flush)
            r_flush_pend <= 1'b1;
          if (mem_ack) begin
            r_state <= S_FILL;
            mem_req <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_FILL: begin
          if (flush)
            r_flush_pend <= 1'b1;
          if (w_fill_wr)
            r_cnt <= r_cnt + OB'(1);
          if (w_fill_last) begin
            r_valid[f_index(r_miss_line)] <= 1'b1;
            r_state <= S_RESTART;
          end
        end
        S_RESTART: begin
          // A flush seen during the refill also wipes the line just written.
          if (flush || r_flush_pend)
            r_valid <= '0;
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_cache.md
# prog_cache

Direct-mapped, read-only instruction cache that is the responder side of the CPU program-fetch interface. The PC unit drives `prg_address` every cycle and samples `p_cache_miss`. This block returns the addressed 16-bit instruction word one cycle later, or holds `p_cache_miss` high while it refills the line from the SDRAM controller via a request/ack/burst handshake. It sits between the PC/decoder and the SDRAM arbiter in the NeonFox CPU top level.

## Interface
Parameters:
- LINE_WORDS, 8, words per line; power of two, 2..32
- LINES, 64, number of lines; power of two, 2..256

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- prg_address  in  32  instruction word address from PC, sampled every edge
- instruction  out  16  instruction word for the address sampled on the previous edge
- p_cache_miss  out  1  instruction not valid this cycle; PC must hold or replay the address
- flush  in  1  invalidate all lines (single-cycle pulse)
- mem_req  out  1  line fill request; held until mem_ack
- mem_addr  out  32  line-aligned word address of the fill; low log2(LINE_WORDS) bits are 0
- mem_ack  in  1  request accepted; one-cycle pulse
- mem_rdata  in  16  fill data word
- mem_rvalid  in  1  mem_rdata valid; exactly LINE_WORDS pulses per request, in ascending word order, not necessarily contiguous

## Operation
- Address split: word offset [OB-1:0], index [OB+IB-1:OB], tag = remaining upper bits. OB = log2(LINE_WORDS), IB = log2(LINES).
- Storage:
  - data RAM of LINES*LINE_WORDS x16, synchronous read;
  - tag RAM of LINES entries, synchronous read;
  - valid bits in flops, cleared by rst.
- Every edge, `prg_address` is registered into `addr_q` and the data/tag RAMs are read at it. `lookup_v` is set to 1 on every edge after reset.
- `hit` = `lookup_v` & valid[index(addr_q)] & (tag_rd == tag(addr_q)).
- FSM states:
  - IDLE: `p_cache_miss` = ~`hit`. On a miss, `miss_addr` <= `addr_q` and the FSM goes to REQ.
  - REQ: `mem_req`=1, `mem_addr` = `miss_addr` with offset zeroed. On `mem_ack`, the FSM goes to FILL and the word counter is set to 0.
  - FILL: each `mem_rvalid` writes `mem_rdata` to data[index(miss_addr)][counter] and increments the counter. On the last word, it writes the tag, sets the valid bit, and goes to RESTART.
  - RESTART: one cycle so that the RAM read of the currently presented address sees the new line. Then the FSM goes to IDLE.
- `p_cache_miss` = 1 in REQ, FILL and RESTART.
- `instruction` = data RAM output in every state; it is only meaningful when `p_cache_miss`=0.
- `mem_rvalid` outside FILL is ignored. `mem_ack` outside REQ is ignored.
- `flush`:
  - In IDLE it clears all valid bits at the next edge. A lookup in that same cycle still uses the old valid bits.
  - In REQ, FILL or RESTART it is latched and applied on entry to IDLE. The line being filled is invalidated too.
- No fill is aborted. A new `prg_address` during a fill does not redirect the fill. The PC replays the missed address, and a different address simply misses again after RESTART.

## Timing
- Hit latency: address at edge N produces `instruction` valid and `p_cache_miss`=0 during cycle N+1.
- Miss: `p_cache_miss`=1 from cycle N+1 (combinational from `hit`). `mem_req` rises at edge N+2.
- Best-case fill (ack in the same cycle as req, back-to-back rvalid starting one cycle after ack): the miss lasts LINE_WORDS+3 cycles, then a hit on the replayed address.
- Reset values, and values held while `rst` is high:
  - `p_cache_miss`=0 (`lookup_v`=0)
  - `mem_req`=0, `mem_addr`=0
  - state IDLE, all valid bits 0, pending-flush 0
  - `instruction` undefined
- `rst` asserted mid-fill returns to IDLE immediately and drops `mem_req`. The partially filled line stays invalid. The controller must be reset by the same `rst`.
- Wrap-around: the word counter wraps to 0 after LINE_WORDS-1. Only that final word triggers the tag/valid write.

## Test plan
- Cold start: release rst, hold `prg_address`=0x100, fill words 0xA000+i -> `mem_req`=1, `mem_addr`=0x100. Then `p_cache_miss` drops and `instruction`=0xA000.
- Sequential hits: after the fill of 0x100, step 0x100..0x107 one per cycle -> `instruction` 0xA000..0xA007 on consecutive cycles, `p_cache_miss`=0 throughout, no `mem_req`.
- Conflict eviction with LINES=64, LINE_WORDS=8: access 0x100, then 0x300 (same index 0x20, different tag) -> refill with `mem_addr`=0x300. Re-accessing 0x100 misses again.
- Stalled fill: `mem_ack` after 5 cycles, `mem_rvalid` gaps of 2 cycles -> `p_cache_miss` high until one cycle after RESTART, data correct, `mem_req` dropped the cycle after ack.
- Flush during FILL: assert `flush` mid-fill -> the fill completes, all lines invalid on entering IDLE, and the replayed address misses again.
- Reset mid-fill: assert `rst` after 3 fill words -> `mem_req`=0 and `p_cache_miss`=0 immediately. After release, that address misses.
